// File: rtl/pcs_rx_block_lock.sv
// pcs_rx_block_lock: per-lane 66b sync-header block lock FSM with gearbox slip control
module pcs_rx_block_lock #(
  parameter int LANE_N      = 4,
  parameter int HEAD_W      = 2,
  parameter int LOCK_CNT_N  = 64,
  parameter int INVLD_MAX_N = 16,
  parameter int SLIP_WAIT_N = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [LANE_N-1:0]          serdes_v_i,
  input  logic [LANE_N*HEAD_W-1:0]   serdes_head_i,
  output logic [LANE_N-1:0]          gearbox_slip_o,
  output logic [LANE_N-1:0]          block_lock_o,
  output logic                       all_lock_o
);
  localparam int SH_W = $clog2(LOCK_CNT_N + 1);
  localparam int IV_W = $clog2(INVLD_MAX_N + 1);
  localparam int WT_W = $clog2(SLIP_WAIT_N + 1);
  typedef enum logic {TEST, SLIP_WAIT} state_t;
  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    state_t            state, state_nx;
    logic [SH_W-1:0]   sh, sh_nx;
    logic [IV_W-1:0]   iv, iv_nx;
    logic [WT_W-1:0]   wt, wt_nx;
    logic              lock, lock_nx, slip, slip_nx;
    logic [HEAD_W-1:0] head;
    logic              hv, wait_done;
    assign head      = serdes_head_i[g*HEAD_W +: HEAD_W];
    assign hv        = head == HEAD_W'(1) || head == HEAD_W'(2);
    assign wait_done = wt == WT_W'(SLIP_WAIT_N - 1);
    // lane state, counters and registered outputs
    always_ff @(posedge clk) begin
      if (nreset) begin
        state <= TEST;
        sh    <= '0;
        iv    <= '0;
        wt    <= '0;
        lock  <= 1'b0;
        slip  <= 1'b0;
      end else begin
        state <= state_nx;
        sh    <= sh_nx;
        iv    <= iv_nx;
        wt    <= wt_nx;
        lock  <= lock_nx;
        slip  <= slip_nx;
      end
    end
    // next state: the wait runs on every clock, header evaluation only on beats; unlock beats window end
    always_comb begin
      state_nx = state;
      sh_nx    = sh;
      iv_nx    = iv;
      wt_nx    = wt;
      lock_nx  = lock;
      slip_nx  = 1'b0;
      if (state == SLIP_WAIT) begin
        wt_nx    = wait_done ? '0 : wt + WT_W'(1);
        state_nx = wait_done ? TEST : SLIP_WAIT;
      end else if (serdes_v_i[g]) begin
        if (!hv && (!lock || iv == IV_W'(INVLD_MAX_N - 1))) begin
          state_nx = SLIP_WAIT;
          slip_nx  = 1'b1;
          lock_nx  = 1'b0;
          sh_nx    = '0;
          iv_nx    = '0;
        end else if (sh == SH_W'(LOCK_CNT_N - 1)) begin
          lock_nx = 1'b1;
          sh_nx   = '0;
          iv_nx   = '0;
        end else begin
          sh_nx = sh + SH_W'(1);
          iv_nx = iv + IV_W'(!hv);
        end
      end
    end
    // per-lane outputs straight from registers
    always_comb begin
      gearbox_slip_o[g] = slip;
      block_lock_o[g]   = lock;
    end
  end
  // aggregate lock
  always_comb all_lock_o = &block_lock_o;
endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// tb_pcs_rx_block_lock: directed self-checking bench for pcs_rx_block_lock
module tb_pcs_rx_block_lock;
  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [3:0] v = '0;
  logic [7:0] h = '0;
  logic [3:0] slip, lock;
  logic       all_lock;
  int         errors = 0;
  int         checks = 0;

  pcs_rx_block_lock dut (
    .clk(clk),
    .nreset(nreset),
    .serdes_v_i(v),
    .serdes_head_i(h),
    .gearbox_slip_o(slip),
    .block_lock_o(lock),
    .all_lock_o(all_lock)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [3:0] vv, input logic [7:0] hh);
    v = vv;
    h = hh;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] es, input logic [3:0] el, input logic ea);
    check({tag, "_slip"}, slip, es);
    check({tag, "_lock"}, lock, el);
    check({tag, "_all"}, all_lock, ea);
  endtask

  initial begin
    // reset with random headers
    repeat (3) begin
      beat(4'hF, 8'($urandom));
      check_all("reset", 4'h0, 4'h0, 1'b0);
    end
    nreset = 1'b0;
    beat(4'hF, 8'h55);
    check_all("post_reset", 4'h0, 4'h0, 1'b0);
    // lock acquisition: lane 0 first, then lanes 1-3
    repeat (62) beat(4'h1, 8'h55);
    check_all("acq_63", 4'h0, 4'h0, 1'b0);
    beat(4'h1, 8'h55);
    check_all("acq_64", 4'h0, 4'h1, 1'b0);
    repeat (62) beat(4'hE, 8'h55);
    check_all("acq_rest_63", 4'h0, 4'h1, 1'b0);
    beat(4'hE, 8'h55);
    check_all("acq_all", 4'h0, 4'hF, 1'b1);
    // hysteresis: 15 invalid in a window keeps lock
    repeat (15) beat(4'h1, 8'h54);
    repeat (49) beat(4'h1, 8'h55);
    check_all("hyst_15", 4'h0, 4'hF, 1'b1);
    repeat (15) beat(4'h1, 8'h54);
    check_all("hyst_w2_15", 4'h0, 4'hF, 1'b1);
    beat(4'h1, 8'h54);
    check_all("hyst_16", 4'h1, 4'hE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(4'h1, 8'h57);
      check("hyst_wait_slip", slip, 4'h0);
    end
    // slip while unlocked at beat 30
    repeat (29) beat(4'h1, 8'h55);
    check_all("unl_29", 4'h0, 4'hE, 1'b0);
    beat(4'h1, 8'h54);
    check_all("unl_slip", 4'h1, 4'hE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(4'h1, 8'h57);
      check("unl_wait_slip", slip, 4'h0);
    end
    repeat (63) beat(4'h1, 8'h55);
    check_all("relock_63", 4'h0, 4'hE, 1'b0);
    beat(4'h1, 8'h55);
    check_all("relock_64", 4'h0, 4'hF, 1'b1);
    // 16th invalid on the 64th beat of a window: unlock wins
    repeat (48) beat(4'h1, 8'h55);
    repeat (15) beat(4'h1, 8'h54);
    check_all("edge_63", 4'h0, 4'hF, 1'b1);
    beat(4'h1, 8'h54);
    check_all("edge_64", 4'h1, 4'hE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, 8'h00);
      check("edge_wait_slip", slip, 4'h0);
    end
    // bubbles between valid beats
    for (int i = 0; i < 63; i++) begin
      beat(4'h1, 8'h55);
      check("bub_v_slip", slip, 4'h0);
      beat(4'h0, 8'h00);
      check("bub_b_slip", slip, 4'h0);
    end
    check_all("bub_63", 4'h0, 4'hE, 1'b0);
    beat(4'h1, 8'h55);
    check_all("bub_64", 4'h0, 4'hF, 1'b1);
    // lane 2 slips alone
    repeat (15) beat(4'h4, 8'h45);
    check_all("ind_15", 4'h0, 4'hF, 1'b1);
    beat(4'h4, 8'h45);
    check_all("ind_slip", 4'h4, 4'hB, 1'b0);
    beat(4'h0, 8'h00);
    check_all("ind_wait", 4'h0, 4'hB, 1'b0);
    // reset during lane 2 wait
    nreset = 1'b1;
    beat(4'hF, 8'h55);
    check_all("mid_reset", 4'h0, 4'h0, 1'b0);
    nreset = 1'b0;
    for (int i = 0; i < 63; i++) begin
      beat(4'hF, 8'h55);
      check("rel_slip", slip, 4'h0);
    end
    check_all("rel_63", 4'h0, 4'h0, 1'b0);
    beat(4'hF, 8'h55);
    check_all("rel_64", 4'h0, 4'hF, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
